// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Used by the hazard detection and forwarding units.
package pipeline_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hdu_state_e;

    localparam int DEF_ADDR_W = 16;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Hazard unit signal bundle.
// slave: hazard unit side; master: pipeline side.
interface hazard_detection_unit_if
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 32
);

    logic              mem_read_ID_EX;
    logic [ADDR_W-1:0] RegisterRD_ID_EX;
    logic [ADDR_W-1:0] RS1_IF_ID;
    logic [ADDR_W-1:0] RS2_IF_ID;
    logic              uses_rs2_IF_ID;
    logic              branch_taken_EX;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic              flush_IF_ID;
    logic              flush_ID_EX;
    logic [CNT_W-1:0]  stall_cycles;

    modport slave (
        input  mem_read_ID_EX,
        input  RegisterRD_ID_EX,
        input  RS1_IF_ID,
        input  RS2_IF_ID,
        input  uses_rs2_IF_ID,
        input  branch_taken_EX,
        output pc_write,
        output if_id_write,
        output id_ex_bubble,
        output flush_IF_ID,
        output flush_ID_EX,
        output stall_cycles
    );

    modport master (
        output mem_read_ID_EX,
        output RegisterRD_ID_EX,
        output RS1_IF_ID,
        output RS2_IF_ID,
        output uses_rs2_IF_ID,
        output branch_taken_EX,
        input  pc_write,
        input  if_id_write,
        input  id_ex_bubble,
        input  flush_IF_ID,
        input  flush_ID_EX,
        input  stall_cycles
    );

endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and taken-branch flush controller.
// Mealy outputs; multi-cycle load latency via a down-counter.
module hazard_detection_unit
    import pipeline_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input logic               clk,
    input logic               rst_n,
    hazard_detection_unit_if.slave hz_if
);

    localparam int CW = $clog2(LOAD_STALL) + 1;

    hdu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hz;
    logic            rd_nz;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [CNT_W-1:0] stall_cnt;

    assign rd_nz   = hz_if.RegisterRD_ID_EX != ADDR_W'(REG_ZERO);
    assign rs1_hit = hz_if.RegisterRD_ID_EX == hz_if.RS1_IF_ID;
    assign rs2_hit = hz_if.uses_rs2_IF_ID &&
                     (hz_if.RegisterRD_ID_EX == hz_if.RS2_IF_ID);
    assign hz      = hz_if.mem_read_ID_EX && rd_nz &&
                     (rs1_hit || rs2_hit);

    always_comb begin
        hz_if.pc_write     = 1'b1;
        hz_if.if_id_write  = 1'b1;
        hz_if.id_ex_bubble = 1'b0;
        hz_if.flush_IF_ID  = 1'b0;
        hz_if.flush_ID_EX  = 1'b0;
        state_d            = state_q;
        cnt_d              = cnt_q;
        if (!rst_n) begin
            hz_if.pc_write     = 1'b0;
            hz_if.if_id_write  = 1'b0;
            hz_if.id_ex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hz_if.branch_taken_EX) begin
                        hz_if.flush_IF_ID = 1'b1;
                        hz_if.flush_ID_EX = 1'b1;
                    end else if (hz) begin
                        hz_if.pc_write     = 1'b0;
                        hz_if.if_id_write  = 1'b0;
                        hz_if.id_ex_bubble = 1'b1;
                        if (LOAD_STALL > 1) begin
                            cnt_d   = CW'(LOAD_STALL - 1);
                            state_d = STALL;
                        end
                    end
                end
                STALL: begin
                    // A taken branch squashes the waiting instruction anyway
                    if (hz_if.branch_taken_EX) begin
                        hz_if.flush_IF_ID = 1'b1;
                        hz_if.flush_ID_EX = 1'b1;
                        cnt_d             = '0;
                        state_d           = RUN;
                    end else begin
                        hz_if.pc_write     = 1'b0;
                        hz_if.if_id_write  = 1'b0;
                        hz_if.id_ex_bubble = 1'b1;
                        cnt_d              = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (!rst_n),
        .inc   (!hz_if.pc_write),
        .count (stall_cnt)
    );

    assign hz_if.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench: two hazard units (LOAD_STALL=1 / LOAD_STALL=3, CNT_W=4)
// driven in parallel against a cycle-level behavioural model.
module tb_hazard_detection_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic [15:0] rd;
    logic [15:0] rs1;
    logic [15:0] rs2;
    logic        uses_rs2;
    logic        br;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_no   = 0;

    int              rem [2];
    longint unsigned scnt[2];
    int              ls  [2];
    longint unsigned smax[2];

    always #5 clk = ~clk;

    hazard_detection_unit_if #(.ADDR_W(16), .CNT_W(32)) i1 ();
    hazard_detection_unit_if #(.ADDR_W(16), .CNT_W(4))  i3 ();

    assign i1.mem_read_ID_EX   = mem_read;
    assign i1.RegisterRD_ID_EX = rd;
    assign i1.RS1_IF_ID        = rs1;
    assign i1.RS2_IF_ID        = rs2;
    assign i1.uses_rs2_IF_ID   = uses_rs2;
    assign i1.branch_taken_EX  = br;
    assign i3.mem_read_ID_EX   = mem_read;
    assign i3.RegisterRD_ID_EX = rd;
    assign i3.RS1_IF_ID        = rs1;
    assign i3.RS2_IF_ID        = rs2;
    assign i3.uses_rs2_IF_ID   = uses_rs2;
    assign i3.branch_taken_EX  = br;

    hazard_detection_unit #(
        .ADDR_W(16), .LOAD_STALL(1), .CNT_W(32)
    ) d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_if (i1.slave)
    );

    hazard_detection_unit #(
        .ADDR_W(16), .LOAD_STALL(3), .CNT_W(4)
    ) d3 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_if (i3.slave)
    );

    task automatic check(input string tag,
                         input longint unsigned got,
                         input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc_no, got, exp);
        end
    endtask

    // Compare both units against the model, then advance the model one edge
    task automatic eval();
        bit hz;
        bit epc, eif, eb, ef;
        bit [4:0] got;
        longint unsigned gcnt;
        string nm;
        hz = mem_read && (rd != 0) &&
             ((rd == rs1) || (uses_rs2 && (rd == rs2)));
        for (int k = 0; k < 2; k++) begin
            nm  = (k == 0) ? "ls1" : "ls3";
            epc = 1; eif = 1; eb = 0; ef = 0;
            if (k == 0) begin
                got  = {i1.pc_write, i1.if_id_write, i1.id_ex_bubble,
                        i1.flush_IF_ID, i1.flush_ID_EX};
                gcnt = 64'(i1.stall_cycles);
            end else begin
                got  = {i3.pc_write, i3.if_id_write, i3.id_ex_bubble,
                        i3.flush_IF_ID, i3.flush_ID_EX};
                gcnt = 64'(i3.stall_cycles);
            end
            check({nm, ".stall_cycles"}, gcnt, scnt[k]);
            if (!rst_n) begin
                epc = 0; eif = 0; eb = 1;
                rem[k]  = 0;
                scnt[k] = 0;
            end else if (br) begin
                ef = 1;
                rem[k] = 0;
            end else if (rem[k] > 0) begin
                epc = 0; eif = 0; eb = 1;
                rem[k] = rem[k] - 1;
            end else if (hz) begin
                epc = 0; eif = 0; eb = 1;
                rem[k] = ls[k] - 1;
            end
            if (rst_n && !epc && scnt[k] < smax[k])
                scnt[k] = scnt[k] + 1;
            check({nm, ".pc_write"},     64'(got[4]), 64'(epc));
            check({nm, ".if_id_write"},  64'(got[3]), 64'(eif));
            check({nm, ".id_ex_bubble"}, 64'(got[2]), 64'(eb));
            check({nm, ".flush_IF_ID"},  64'(got[1]), 64'(ef));
            check({nm, ".flush_ID_EX"},  64'(got[0]), 64'(ef));
        end
    endtask

    task automatic cyc(input bit r, input bit mr,
                       input int d, input int a, input int b,
                       input bit u, input bit t);
        rst_n    = r;
        mem_read = mr;
        rd       = 16'(d);
        rs1      = 16'(a);
        rs2      = 16'(b);
        uses_rs2 = u;
        br       = t;
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 1, 2, 0, 0);
    endtask

    initial begin
        ls[0] = 1;  smax[0] = 64'hFFFF_FFFF;
        ls[1] = 3;  smax[1] = 64'd15;
        for (int k = 0; k < 2; k++) begin
            rem[k]  = 0;
            scnt[k] = 0;
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // rs1 load-use, then ID moves on
        cyc(1, 1, 5, 5, 9, 0, 0);
        idle(4);
        // rs2 load-use with and without uses_rs2
        cyc(1, 1, 7, 1, 7, 1, 0);
        idle(4);
        cyc(1, 1, 7, 1, 7, 0, 0);
        idle(2);
        // register zero and non-load
        cyc(1, 1, 0, 0, 0, 1, 0);
        cyc(1, 0, 5, 5, 5, 1, 0);
        // branch with hazard, then branch in 2nd stall cycle
        cyc(1, 1, 5, 5, 0, 0, 1);
        idle(1);
        cyc(1, 1, 6, 6, 0, 0, 0);
        cyc(1, 0, 0, 6, 0, 0, 1);
        idle(3);
        // reset in 2nd cycle of a stall
        cyc(1, 1, 6, 6, 0, 0, 0);
        cyc(0, 0, 0, 6, 0, 0, 0);
        idle(3);
        // long held hazard drives the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) cyc(1, 1, 3, 3, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            int d, a, b;
            d = $urandom_range(0, 3);
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) d = int'($urandom & 16'hFFFF);
            cyc($urandom_range(0, 39) != 0,
                $urandom_range(0, 1) == 1,
                d, a, b,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
Stall and flush controller for the 5-stage pipeline, the counterpart to the forwarding unit. The forwarding unit resolves RAW hazards by routing results forward. This block handles the hazards forwarding cannot cover: load-use, including a configurable multi-cycle load latency, and taken-branch flushes. It drives the PC and IF/ID write enables, inserts an ID/EX bubble and keeps a stall-cycle performance counter.

Parameters:
ADDR_W, 16, register-address width; matches the forwarding-unit RS/RD buses
LOAD_STALL, 1, total stall cycles per load-use hazard (>=1)
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
mem_read_ID_EX  in  1  instruction in EX is a load
RegisterRD_ID_EX  in  ADDR_W  destination of the instruction in EX
RS1_IF_ID  in  ADDR_W  rs1 of the instruction in ID
RS2_IF_ID  in  ADDR_W  rs2 of the instruction in ID
uses_rs2_IF_ID  in  1  instruction in ID reads rs2
branch_taken_EX  in  1  branch/jump resolved taken in EX this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register write enable
id_ex_bubble  out  1  zero ID/EX control signals (insert NOP)
flush_IF_ID  out  1  clear IF/ID
flush_ID_EX  out  1  clear ID/EX
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- One clock, clk. Reset is synchronous and active-low: rst_n is sampled on the rising clk edge.
- FSM states: RUN, STALL. Down-counter cnt is $clog2(LOAD_STALL)+1 bits wide.
- Hazard condition: hz = mem_read_ID_EX && RegisterRD_ID_EX!=0 && (RegisterRD_ID_EX==RS1_IF_ID || (uses_rs2_IF_ID && RegisterRD_ID_EX==RS2_IF_ID)).
- Outputs are Mealy (combinational from state + inputs). Defaults: pc_write=1, if_id_write=1, bubble=0, flushes=0.
- RUN, branch_taken_EX=1:
  - flush_IF_ID=1, flush_ID_EX=1, pc_write=1, no stall.
  - Branch has priority over hz.
  - Next state RUN.
- RUN, hz=1 with no branch:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If LOAD_STALL>1: cnt<=LOAD_STALL-1, next state STALL.
  - Otherwise stay in RUN. The bubble advances the load, so hz clears naturally.
- STALL:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - cnt decrements each cycle. When cnt==1, next state RUN.
  - Total stalled cycles for one hazard = LOAD_STALL exactly.
  - hz is ignored while in STALL. The ID instruction is held and re-checked on return to RUN.
- STALL with branch_taken_EX=1: flushes asserted, pc_write=1, stall aborted, cnt<=0, next state RUN.
- stall_cycles:
  - Increments on each clk edge where pc_write==0 and rst_n==1.
  - Saturates at all-ones, no wrap.
- While rst_n==0: pc_write=0, if_id_write=0, id_ex_bubble=1, flushes=0.
- On a clk edge with rst_n==0: state<=RUN, cnt<=0, stall_cycles<=0. Applies mid-stall too; the stall is abandoned.
- First cycle after reset release: RUN with default outputs, subject to hz.
- Register 0 never causes a stall. Comparisons are full ADDR_W equality.
- Load followed by another dependent load: handled per hazard, with no merging of stall windows.

Decomposition:
- Shared package pipeline_pkg:
  - state enum {RUN, STALL}
  - REG_ZERO constant
  - default ADDR_W, shared with forward_unit
- Natural sub-module: sat_counter (parameter W; inc, clear; saturating). Reusable for other performance counters.
- FSM and hazard compare stay in the top module.

Test Plan:
- LOAD_STALL=1. Load rd=5 in EX, ID rs1=5 -> one cycle pc_write=0, if_id_write=0, bubble=1, then defaults. stall_cycles=1.
- LOAD_STALL=3. Load rd=7, ID rs2=7, uses_rs2=1 -> exactly 3 consecutive stall cycles, then RUN. stall_cycles=3. Repeat with uses_rs2=0 -> no stall.
- Load rd=0 with rs1=0, and non-load rd=5 with rs1=5 -> no stall, and no flush.
- branch_taken_EX=1 in the same cycle as hz -> flush_IF_ID=1, flush_ID_EX=1, pc_write=1, bubble=0. With LOAD_STALL=3, a branch in the 2nd stall cycle -> stall aborts, RUN next cycle.
- rst_n=0 asserted in the 2nd cycle of a 3-cycle stall -> next edge state RUN, stall_cycles=0. During reset pc_write=0, bubble=1.
- CNT_W=4, 20 stall cycles -> stall_cycles saturates at 15 and does not wrap.
